// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the memory/IO bus arbiter.
// Default parameters live here so the picker and the top agree on widths.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_OWN   = 2'b01,
        ST_ABORT = 2'b10
    } arb_state_e;

    localparam int DEF_NUM_M   = 3;
    localparam int DEF_TIMEOUT = 255;
    localparam int DEF_PTR_W   = $clog2(DEF_NUM_M);

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Watchdog only needs to reach TIMEOUT-1.
    function automatic int wd_width(input int t);
        return (t > 1) ? $clog2(t) : 1;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr wins,
// searching upward and wrapping modulo NUM_M.
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int NUM_M = DEF_NUM_M,
    parameter int PTR_W = ptr_width(NUM_M)
) (
    input  logic [NUM_M-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NUM_M-1:0] win,
    output logic [PTR_W-1:0] win_idx
);

    logic [PTR_W-1:0] cand_idx [NUM_M];

    // cand_idx[i] is the slot examined at search position i.
    generate
        for (genvar gi = 0; gi < NUM_M; gi++) begin : g_cand
            logic [PTR_W:0] sum;
            logic [PTR_W:0] wrapped;
            assign sum     = {1'b0, ptr} + (PTR_W+1)'(gi);
            assign wrapped = (sum >= (PTR_W+1)'(NUM_M)) ? (sum - (PTR_W+1)'(NUM_M)) : sum;
            assign cand_idx[gi] = wrapped[PTR_W-1:0];
        end
    endgenerate

    always_comb begin
        logic found;
        found   = 1'b0;
        win_idx = '0;
        win     = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (!found && req[cand_idx[i]]) begin
                found   = 1'b1;
                win_idx = cand_idx[i];
            end
        end
        if (found) begin
            win = NUM_M'(1) << win_idx;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter for the shared memory/IO bus with a no-ack watchdog.
// A grant is held for as long as the owner keeps cyc high, so bursts never interleave.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_M   = DEF_NUM_M,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_M-1:0]      m_cyc,
    input  logic [NUM_M-1:0]      m_we,
    input  logic [4*NUM_M-1:0]    m_strb,
    input  logic [32*NUM_M-1:0]   m_addr,
    input  logic [32*NUM_M-1:0]   m_data_o,
    output logic [NUM_M-1:0]      m_ack,
    output logic [NUM_M-1:0]      m_err,
    output logic [31:0]           m_data_i,
    output logic                  s_cyc,
    output logic                  s_we,
    output logic [3:0]            s_strb,
    output logic [31:0]           s_addr,
    output logic [31:0]           s_data_o,
    input  logic                  s_ack,
    input  logic [31:0]           s_data_i,
    output logic [NUM_M-1:0]      gnt
);

    localparam int PTR_W = ptr_width(NUM_M);
    localparam int WD_W  = wd_width(TIMEOUT);

    arb_state_e        state_q,  state_d;
    logic [NUM_M-1:0]  gnt_q,    gnt_d;
    logic [PTR_W-1:0]  ptr_q,    ptr_d;
    logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;

    logic [NUM_M-1:0]  win;
    logic [PTR_W-1:0]  win_idx;
    logic [PTR_W-1:0]  next_ptr;
    logic              owner_cyc;
    logic              any_req;

    rr_pick #(
        .NUM_M (NUM_M),
        .PTR_W (PTR_W)
    ) u_pick (
        .req     (m_cyc),
        .ptr     (ptr_q),
        .win     (win),
        .win_idx (win_idx)
    );

    assign next_ptr  = (win_idx == PTR_W'(NUM_M-1)) ? '0 : win_idx + PTR_W'(1);
    assign owner_cyc = |(m_cyc & gnt_q);
    assign any_req   = |m_cyc;

    // Owner-slot fields, zeroed for non-owners so they can be OR-combined.
    logic [31:0] slot_addr [NUM_M];
    logic [31:0] slot_data [NUM_M];
    logic [3:0]  slot_strb [NUM_M];
    logic        slot_we   [NUM_M];

    generate
        for (genvar gi = 0; gi < NUM_M; gi++) begin : g_slot
            assign slot_addr[gi] = gnt_q[gi] ? m_addr[gi*32 +: 32]   : 32'd0;
            assign slot_data[gi] = gnt_q[gi] ? m_data_o[gi*32 +: 32] : 32'd0;
            assign slot_strb[gi] = gnt_q[gi] ? m_strb[gi*4 +: 4]     : 4'd0;
            assign slot_we[gi]   = gnt_q[gi] & m_we[gi];
        end
    endgenerate

    logic [31:0] own_addr;
    logic [31:0] own_data;
    logic [3:0]  own_strb;
    logic        own_we;

    always_comb begin
        own_addr = '0;
        own_data = '0;
        own_strb = '0;
        own_we   = 1'b0;
        for (int k = 0; k < NUM_M; k++) begin
            own_addr = own_addr | slot_addr[k];
            own_data = own_data | slot_data[k];
            own_strb = own_strb | slot_strb[k];
            own_we   = own_we   | slot_we[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            ptr_q    <= '0;
            wd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            ptr_q    <= ptr_d;
            wd_cnt_q <= wd_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        ptr_d    = ptr_q;
        wd_cnt_d = wd_cnt_q;
        s_cyc    = 1'b0;
        s_we     = 1'b0;
        s_strb   = '0;
        s_addr   = '0;
        s_data_o = '0;
        m_ack    = '0;
        m_err    = '0;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d  = ST_OWN;
                    gnt_d    = win;
                    ptr_d    = next_ptr;
                    wd_cnt_d = '0;
                end
            end

            ST_OWN: begin
                s_cyc    = owner_cyc;
                s_we     = own_we;
                s_strb   = own_strb;
                s_addr   = own_addr;
                s_data_o = own_data;
                m_ack    = gnt_q & {NUM_M{s_ack & owner_cyc}};

                // Release takes priority; the owner's cyc is low so it cannot re-win.
                if (!owner_cyc) begin
                    if (any_req) begin
                        gnt_d    = win;
                        ptr_d    = next_ptr;
                        wd_cnt_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                    end
                end else if (s_ack) begin
                    wd_cnt_d = '0;
                end else if (TIMEOUT != 0 && wd_cnt_q == WD_W'(TIMEOUT-1)) begin
                    state_d = ST_ABORT;
                end else begin
                    wd_cnt_d = wd_cnt_q + WD_W'(1);
                end
            end

            ST_ABORT: begin
                m_err    = gnt_q;
                state_d  = ST_IDLE;
                gnt_d    = '0;
                wd_cnt_d = '0;
            end

            default: begin
                state_d  = ST_IDLE;
                gnt_d    = '0;
                wd_cnt_d = '0;
            end
        endcase
    end

    assign m_data_i = s_data_i;
    assign gnt      = gnt_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level model of owner/pointer/no-ack count.
module tb_mem_bus_arbiter;

    localparam int N = 3;
    localparam int T = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      m_cyc, m_we;
    logic [4*N-1:0]    m_strb;
    logic [32*N-1:0]   m_addr, m_data_o;
    logic [N-1:0]      m_ack, m_err, gnt;
    logic [31:0]       m_data_i;
    logic              s_cyc, s_we;
    logic [3:0]        s_strb;
    logic [31:0]       s_addr, s_data_o;
    logic              s_ack;
    logic [31:0]       s_data_i;

    mem_bus_arbiter #(.NUM_M(N), .TIMEOUT(T)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m_cyc    (m_cyc),
        .m_we     (m_we),
        .m_strb   (m_strb),
        .m_addr   (m_addr),
        .m_data_o (m_data_o),
        .m_ack    (m_ack),
        .m_err    (m_err),
        .m_data_i (m_data_i),
        .s_cyc    (s_cyc),
        .s_we     (s_we),
        .s_strb   (s_strb),
        .s_addr   (s_addr),
        .s_data_o (s_data_o),
        .s_ack    (s_ack),
        .s_data_i (s_data_i),
        .gnt      (gnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: who owns the bus, where the next search starts, how many un-acked cycles so far.
    int mo_owner = -1;
    int mo_ptr   = 0;
    int mo_nack  = 0;
    bit mo_abort = 1'b0;

    bit          one_beat = 1'b0;
    logic [N-1:0] last_gnt, last_ack, last_err, prev_gnt;
    int          ack_cnt [N];
    int          grant_log [$];
    logic [N-1:0] errs [7];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick();
        for (int i = 0; i < N; i++) begin
            int j;
            j = (mo_ptr + i) % N;
            if (m_cyc[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_step();
        if (mo_abort) begin
            mo_abort = 1'b0;
            mo_owner = -1;
        end else if (mo_owner >= 0) begin
            if (!m_cyc[mo_owner]) begin
                int w;
                w = pick();
                mo_owner = w;
                if (w >= 0) begin
                    mo_ptr  = (w + 1) % N;
                    mo_nack = 0;
                end
            end else if (s_ack) begin
                mo_nack = 0;
            end else begin
                mo_nack++;
                if (mo_nack == T) mo_abort = 1'b1;
            end
        end else begin
            int w;
            w = pick();
            if (w >= 0) begin
                mo_owner = w;
                mo_ptr   = (w + 1) % N;
                mo_nack  = 0;
            end
        end
    endtask

    task automatic model_reset();
        mo_owner = -1;
        mo_ptr   = 0;
        mo_nack  = 0;
        mo_abort = 1'b0;
        prev_gnt = '0;
    endtask

    task automatic new_data();
        m_we     = N'($urandom);
        m_strb   = (4*N)'($urandom);
        m_addr   = {$urandom, $urandom, $urandom};
        m_data_o = {$urandom, $urandom, $urandom};
        s_data_i = $urandom;
    endtask

    // One clock: check at negedge+1, advance model with the inputs seen at the posedge.
    task automatic cyc();
        logic [N-1:0] e_gnt, e_ack, e_err;
        logic         e_scyc, e_we;
        logic [3:0]   e_strb;
        logic [31:0]  e_addr, e_data;
        bit           own;
        @(negedge clk);
        #1;
        own    = (mo_owner >= 0) && !mo_abort;
        e_gnt  = '0;
        e_ack  = '0;
        e_err  = '0;
        e_scyc = 1'b0;
        e_we   = 1'b0;
        e_strb = '0;
        e_addr = '0;
        e_data = '0;
        if (mo_owner >= 0) e_gnt[mo_owner] = 1'b1;
        if (own) begin
            e_scyc = m_cyc[mo_owner];
            e_we   = m_we[mo_owner];
            e_strb = m_strb[mo_owner*4 +: 4];
            e_addr = m_addr[mo_owner*32 +: 32];
            e_data = m_data_o[mo_owner*32 +: 32];
            if (e_scyc && s_ack) e_ack[mo_owner] = 1'b1;
        end
        if (mo_abort) e_err[mo_owner] = 1'b1;
        chk("gnt", gnt, e_gnt);
        chk("s_cyc", s_cyc, e_scyc);
        chk("s_we", s_we, e_we);
        chk("s_strb", s_strb, e_strb);
        chk("s_addr", s_addr, e_addr);
        chk("s_data_o", s_data_o, e_data);
        chk("m_ack", m_ack, e_ack);
        chk("m_err", m_err, e_err);
        chk("m_data_i", m_data_i, s_data_i);
        if (gnt != '0 && gnt != prev_gnt) grant_log.push_back($clog2(gnt));
        prev_gnt = gnt;
        last_gnt = gnt;
        last_ack = m_ack;
        last_err = m_err;
        for (int k = 0; k < N; k++) if (m_ack[k]) ack_cnt[k]++;
        if (one_beat) m_cyc = m_cyc & ~m_ack;
        @(posedge clk);
        model_step();
        #1;
        new_data();
    endtask

    // Called at posedge+1; checks that reset takes effect without a clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_s_cyc", s_cyc, 1'b0);
        chk("rst_gnt", gnt, '0);
        chk("rst_m_ack", m_ack, '0);
        chk("rst_m_err", m_err, '0);
        chk("rst_s_addr", s_addr, '0);
        chk("rst_m_data_i", m_data_i, s_data_i);
        model_reset();
        #2;
        rst_n = 1'b1;
    endtask

    task automatic clear_counts();
        for (int k = 0; k < N; k++) ack_cnt[k] = 0;
        grant_log.delete();
    endtask

    initial begin
        rst_n  = 1'b0;
        m_cyc  = '0;
        s_ack  = 1'b0;
        new_data();
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Single master, 8-beat read
        clear_counts();
        m_cyc = 3'b001;
        s_ack = 1'b1;
        repeat (9) cyc();
        chk("burst_acks", ack_cnt[0], 8);
        chk("burst_gnt", last_gnt, 3'b001);
        chk("burst_one_grant", grant_log.size(), 1);
        m_cyc = '0;
        cyc();
        cyc();
        chk("burst_idle_gnt", last_gnt, '0);
        $display("burst: acks=%0d grants=%0d", ack_cnt[0], grant_log.size());

        // Contention from reset
        @(posedge clk);
        #1;
        do_reset();
        clear_counts();
        one_beat = 1'b1;
        s_ack    = 1'b1;
        m_cyc    = 3'b111;
        repeat (10) cyc();
        one_beat = 1'b0;
        chk("cont_count", grant_log.size(), 3);
        if (grant_log.size() == 3) begin
            chk("cont_first", grant_log[0], 0);
            chk("cont_second", grant_log[1], 1);
            chk("cont_third", grant_log[2], 2);
        end
        for (int k = 0; k < N; k++) chk("cont_beats", ack_cnt[k], 1);
        $display("contention: grants=%0d", grant_log.size());

        // Locked burst
        m_cyc = 3'b001;
        s_ack = 1'b1;
        repeat (3) cyc();
        m_cyc = 3'b011;
        repeat (4) begin
            cyc();
            chk("lock_gnt", last_gnt, 3'b001);
        end
        m_cyc = 3'b010;
        cyc();
        cyc();
        chk("handover_gnt", last_gnt, 3'b010);
        m_cyc = '0;
        repeat (2) cyc();
        $display("locked burst: handover gnt=%b", 3'b010);

        // Watchdog on master 2
        m_cyc = 3'b100;
        s_ack = 1'b0;
        cyc();
        for (int i = 1; i <= 6; i++) begin
            cyc();
            errs[i] = last_err;
            if (i == 5) m_cyc = '0;
        end
        for (int i = 1; i <= 4; i++) chk("wd_early", errs[i], '0);
        chk("wd_err", errs[5], 3'b100);
        chk("wd_after", errs[6], '0);
        chk("wd_idle_gnt", last_gnt, '0);
        clear_counts();
        one_beat = 1'b1;
        s_ack    = 1'b1;
        m_cyc    = 3'b111;
        repeat (8) cyc();
        one_beat = 1'b0;
        chk("wd_next_count", grant_log.size(), 3);
        if (grant_log.size() > 0) chk("wd_next_first", grant_log[0], 0);
        $display("watchdog: err pulse=%b", errs[5]);

        // Reset during beat 3
        m_cyc = 3'b010;
        s_ack = 1'b1;
        repeat (3) cyc();
        chk("pre_rst_s_cyc", s_cyc, 1'b1);
        do_reset();
        clear_counts();
        m_cyc = 3'b110;
        repeat (2) cyc();
        chk("post_rst_count", grant_log.size(), 1);
        if (grant_log.size() > 0) chk("post_rst_ptr", grant_log[0], 1);
        m_cyc = '0;
        repeat (2) cyc();
        $display("reset mid-burst: first grant after reset checked");

        // Ack/release race
        m_cyc = 3'b011;
        s_ack = 1'b0;
        repeat (2) cyc();
        chk("race_owner", last_gnt, 3'b001);
        m_cyc = 3'b010;
        s_ack = 1'b1;
        cyc();
        chk("race_ack", last_ack, '0);
        cyc();
        chk("race_next", last_gnt, 3'b010);
        m_cyc = '0;
        repeat (2) cyc();
        $display("race: release without ack");

        // Random traffic
        repeat (400) begin
            for (int k = 0; k < N; k++) if ($urandom_range(0, 7) == 0) m_cyc[k] = ~m_cyc[k];
            s_ack = ($urandom_range(0, 9) < 6);
            cyc();
        end
        $display("random: 400 cycles");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Round-robin arbiter and watchdog for the single system memory/IO bus. It sits between up to `NUM_M` bus masters and the one memory/IO slave port. Master 0 is the MMU master interface; further slots are for DMA and the debug port. The block holds a grant for the whole time a master keeps `cyc` asserted, so multi-beat cache line fills and evictions are never interleaved. A watchdog aborts a transfer when the slave never acks.

## Interface
Parameters:
- `NUM_M`, default 3: number of masters, range 2..8.
- `TIMEOUT`, default 255: number of no-ack cycles before an abort. 0 disables the watchdog.

Ports. Reset is asynchronous and active-low; the clock is single-domain. Master buses are packed vectors, with slot *k* at `[k*W +: W]`.
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `m_cyc` in NUM_M: per-master cycle request.
- `m_we` in NUM_M: per-master write enable.
- `m_strb` in 4*NUM_M: per-master byte strobes.
- `m_addr` in 32*NUM_M: per-master address.
- `m_data_o` in 32*NUM_M: per-master write data.
- `m_ack` out NUM_M: ack routed to the owner only.
- `m_err` out NUM_M: one-cycle abort pulse to the owner.
- `m_data_i` out 32: slave read data, broadcast to all masters.
- `s_cyc`, `s_we` out 1; `s_strb` out 4; `s_addr`, `s_data_o` out 32: slave-side bus.
- `s_ack` in 1; `s_data_i` in 32: slave response.
- `gnt` out NUM_M: one-hot current owner; all zero when there is no owner.

## Operation
- States:
  - IDLE: no owner.
  - OWN: the owner in `gnt` drives the slave bus.
  - ABORT: one cycle, entered on watchdog expiry.
- In IDLE, when any `m_cyc` is high at a clock edge, the arbiter selects a winner by round-robin.
  - The search starts at pointer `ptr` and wraps modulo NUM_M.
  - `gnt` is loaded with the winner and the state moves to OWN.
  - `ptr` is set to winner+1, wrapping to 0 after NUM_M-1.
- In OWN, the slave outputs are driven as follows.
  - `s_cyc` = owner's `m_cyc`.
  - `s_we`, `s_strb`, `s_addr` and `s_data_o` are muxed from the owner's slot.
- In OWN, the slave response is routed as follows.
  - `m_ack[owner]` = `s_ack & s_cyc`. All other `m_ack` bits are 0.
  - `m_data_i` = `s_data_i` at all times.
- In OWN, when the owner's `m_cyc` is low at an edge, the owner releases the bus.
  - If another request is pending in the same cycle, the arbiter re-arbitrates directly from OWN (OWN→OWN with the new winner).
  - Otherwise the state moves to IDLE.
- Watchdog:
  - `wd_cnt` clears on entry to OWN and on every cycle with `s_ack`.
  - It increments on each OWN cycle with `s_cyc & ~s_ack`.
  - When `wd_cnt == TIMEOUT-1` and the cycle has no ack, the next state is ABORT.
- In ABORT:
  - `m_err[owner]` = 1, `s_cyc` = 0 and all `m_ack` = 0.
  - The next state is IDLE and `gnt` is cleared.
  - `ptr` is already past the aborted master, so that master becomes lowest priority.
- Outputs outside OWN:
  - `s_cyc`, `s_we`, `s_strb`, `s_addr` and `s_data_o` are all 0.
- Boundary cases:
  - When several requests arrive together, strict round-robin from `ptr` decides.
  - If the owner drops `cyc` in the same cycle as `s_ack`, no ack is delivered because `s_cyc` is low.
  - A master holding `cyc` high through ABORT re-requests as normal.
  - Reset asserted mid-transfer drops `s_cyc` asynchronously.

## Timing
- Reset values:
  - State IDLE, `gnt` 0, `ptr` 0, `wd_cnt` 0.
  - All outputs 0, except `m_data_i`, which follows `s_data_i`.
- Grant latency: a request first seen at edge N is granted from cycle N+1, with `s_cyc` high in cycle N+1.
- Request-to-slave adds one cycle. The ack path is combinational, adding zero cycles.
- Handover gap: at least one cycle with `s_cyc` low between owners, because the releasing owner has its `cyc` low.
- Abort timing with `TIMEOUT` = T: the abort occurs after T consecutive un-acked OWN cycles. `m_err` is high in cycle T+1 after grant.

## Structure
- Package `mem_arb_pkg`, containing:
  - The state encoding (IDLE=2'b00, OWN=2'b01, ABORT=2'b10).
  - The default `NUM_M` and `TIMEOUT`.
  - The width constant for `ptr`, $clog2(NUM_M).
- Sub-module `rr_pick`: a combinational round-robin picker.
  - Inputs: `req[NUM_M]` and `ptr`.
  - Outputs: one-hot `win` and binary `win_idx`.
- The top level contains the FSM, the `gnt` and `ptr` registers, the watchdog counter and the output muxes.

## Test plan
- Single master, MMU 8-beat read:
  - Stimulus: `m_cyc[0]` high for 8 acks.
  - Required: `gnt`=001 from cycle 1 and 8 `m_ack[0]` pulses. `gnt` stays constant throughout, and the state returns to IDLE after `cyc` drops.
- Contention:
  - Stimulus: `m_cyc` = 111 asserted simultaneously from reset, each master doing one beat.
  - Required: grants in order 0, 1, 2, each separated by at least 1 idle `s_cyc` cycle.
- Locked burst:
  - Stimulus: master 1 requests while master 0 is mid-burst.
  - Required: master 1 has no grant until master 0 drops `cyc`, then `gnt`=010 the next cycle.
- Watchdog, TIMEOUT=4:
  - Stimulus: `s_ack` tied low while master 2 is granted.
  - Required: `m_err[2]` is high for exactly one cycle on the 5th cycle after grant, then IDLE, then master 0 or 1 is preferred on the next contention.
- Reset mid-burst:
  - Stimulus: `rst_n` low during beat 3 of a burst.
  - Required: `s_cyc`, `gnt` and `m_ack` go to 0 immediately, and `ptr` becomes 0.
- Ack/release race:
  - Stimulus: owner drops `cyc` in the same cycle as `s_ack`.
  - Required: `m_ack` stays 0 and the next pending master is granted on the following cycle.
